multicycle_control_unit: RTL and testbench

Control unit for the multi-cycle RV32I core. It replaces the single-cycle decoder with an FSM that sequences one instruction through fetch, decode, execute, memory and writeback over 3-5 cycles, with stall cycles added while memory is not ready. Compared with the single-cycle version it adds a memory-ready handshake, bne/blt/bge/bltu/bgeu from ALU flags, jalr, lui, a 4-bit ALU control and illegal-opcode flagging.

---
 rtl/multicycle_control_unit_if.sv | 42 ++++
 rtl/multicycle_control_unit.sv | 181 ++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_unit_if.sv
// Bus between the multi-cycle control unit and the datapath: instruction fields,
// ALU flags and memory ready go in, control selects and enables come back out.
interface multicycle_control_unit_if;
    logic [6:0] i_OpCode;
    logic [2:0] i_funct3;
    logic       i_funct7_5;
    logic       i_Zero;
    logic       i_Negative;
    logic       i_Carry;
    logic       i_Overflow;
    // Memory handshake: the access issued by FETCH/MEMREAD/MEMWRITE completes
    // in a cycle where i_MemReady=1. The address, strobe and state are held
    // unchanged until that cycle.
    logic       i_MemReady;

    logic       o_PCWrite;
    logic       o_AdrSrc;
    logic       o_MemWrite;
    logic       o_IRWrite;
    logic [1:0] o_ResultSrc;
    logic [1:0] o_ALUSrcA;
    logic [1:0] o_ALUSrcB;
    logic [2:0] o_ImmSrc;
    logic       o_RegWrite;
    logic [3:0] o_ALUControl;
    logic       o_Illegal;
    logic [3:0] o_State;

    modport master (
        output i_OpCode, i_funct3, i_funct7_5, i_Zero, i_Negative, i_Carry,
               i_Overflow, i_MemReady,
        input  o_PCWrite, o_AdrSrc, o_MemWrite, o_IRWrite, o_ResultSrc, o_ALUSrcA,
               o_ALUSrcB, o_ImmSrc, o_RegWrite, o_ALUControl, o_Illegal, o_State
    );

    modport slave (
        input  i_OpCode, i_funct3, i_funct7_5, i_Zero, i_Negative, i_Carry,
               i_Overflow, i_MemReady,
        output o_PCWrite, o_AdrSrc, o_MemWrite, o_IRWrite, o_ResultSrc, o_ALUSrcA,
               o_ALUSrcB, o_ImmSrc, o_RegWrite, o_ALUControl, o_Illegal, o_State
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// with registered Moore selects and Mealy PC/IR write enables and illegal flag.
module multicycle_control_unit #(
    parameter bit EXT_BRANCH    = 1'b1,
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input logic i_Clk,
    input logic i_Rst_n,
    multicycle_control_unit_if.slave bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        JALR1    = 4'd11,
        JALR2    = 4'd12,
        LUI      = 4'd13
    } state_t;

    typedef struct packed {
        logic       adr_src;
        logic       mem_write;
        logic [1:0] result_src;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic       reg_write;
        logic [3:0] alu_control;
    } ctrl_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

    localparam ctrl_t FETCH_CTRL = '{adr_src: 1'b0, mem_write: 1'b0, result_src: 2'b10,
                                     src_a: 2'b00, src_b: 2'b10, reg_write: 1'b0,
                                     alu_control: ALU_ADD};

    state_t state;
    state_t next_state;
    state_t dec_next;
    ctrl_t  ctrl;
    logic   ready;
    logic   dec_illegal;
    logic   branch_ok;
    logic   taken;

    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic f7_5,
                                              input logic rtype);
        logic [3:0] fn;
        case (f3)
            3'b000:  fn = (rtype && f7_5) ? ALU_SUB : ALU_ADD;
            3'b001:  fn = 4'b0111;
            3'b010:  fn = 4'b0101;
            3'b011:  fn = 4'b0110;
            3'b100:  fn = 4'b0100;
            3'b101:  fn = f7_5 ? 4'b1001 : 4'b1000;
            3'b110:  fn = 4'b0011;
            default: fn = 4'b0010;
        endcase
        return fn;
    endfunction

    function automatic ctrl_t state_ctrl(input state_t s, input logic [3:0] alu_fn);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH:    c = FETCH_CTRL;
            DECODE:   begin c.src_a = 2'b01; c.src_b = 2'b01; end
            MEMADR:   begin c.src_a = 2'b10; c.src_b = 2'b01; end
            MEMREAD:  c.adr_src = 1'b1;
            MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; end
            MEMWRITE: begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
            EXECR:    begin c.src_a = 2'b10; c.alu_control = alu_fn; end
            EXECI:    begin c.src_a = 2'b10; c.src_b = 2'b01; c.alu_control = alu_fn; end
            ALUWB:    c.reg_write = 1'b1;
            BRANCH:   begin c.src_a = 2'b10; c.alu_control = ALU_SUB; end
            JAL:      begin c.src_a = 2'b01; c.src_b = 2'b10; end
            JALR1:    begin c.src_a = 2'b10; c.src_b = 2'b01; end
            JALR2:    begin c.src_a = 2'b01; c.src_b = 2'b10; end
            LUI:      begin c.src_a = 2'b11; c.src_b = 2'b01; end
            default:  c = FETCH_CTRL;
        endcase
        return c;
    endfunction

    assign ready     = MEM_HANDSHAKE ? bus.i_MemReady : 1'b1;
    // Encodings 010/011 are not RV32I branches; the reduced build only has beq.
    assign branch_ok = EXT_BRANCH ? (bus.i_funct3[2:1] != 2'b01) : (bus.i_funct3 == 3'b000);

    always_comb begin
        dec_next    = FETCH;
        dec_illegal = 1'b0;
        case (bus.i_OpCode)
            OP_LOAD, OP_STORE: dec_next = MEMADR;
            OP_REG:            dec_next = EXECR;
            OP_IMM:            dec_next = EXECI;
            OP_BRANCH:         if (branch_ok) dec_next = BRANCH; else dec_illegal = 1'b1;
            OP_JAL:            dec_next = JAL;
            OP_JALR:           if (bus.i_funct3 == 3'b000) dec_next = JALR1; else dec_illegal = 1'b1;
            OP_LUI:            dec_next = LUI;
            default:           dec_illegal = 1'b1;
        endcase
    end

    always_comb begin
        case (bus.i_funct3)
            3'b000:  taken = bus.i_Zero;
            3'b001:  taken = !bus.i_Zero;
            3'b100:  taken = bus.i_Negative ^ bus.i_Overflow;
            3'b101:  taken = !(bus.i_Negative ^ bus.i_Overflow);
            3'b110:  taken = !bus.i_Carry;
            3'b111:  taken = bus.i_Carry;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:    next_state = ready ? DECODE : FETCH;
            DECODE:   next_state = dec_next;
            MEMADR:   next_state = (bus.i_OpCode == OP_STORE) ? MEMWRITE : MEMREAD;
            MEMREAD:  next_state = ready ? MEMWB : MEMREAD;
            MEMWRITE: next_state = ready ? FETCH : MEMWRITE;
            EXECR, EXECI, JAL, JALR2, LUI: next_state = ALUWB;
            JALR1:    next_state = JALR2;
            default:  next_state = FETCH;
        endcase
    end

    // Moore selects are registered alongside the state, computed from the state being entered.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state <= FETCH;
            ctrl  <= FETCH_CTRL;
        end else begin
            state <= next_state;
            ctrl  <= state_ctrl(next_state,
                                alu_decode(bus.i_funct3, bus.i_funct7_5, next_state == EXECR));
        end
    end

    always_comb begin
        case (bus.i_OpCode)
            OP_STORE:  bus.o_ImmSrc = 3'b001;
            OP_BRANCH: bus.o_ImmSrc = 3'b010;
            OP_JAL:    bus.o_ImmSrc = 3'b011;
            OP_LUI:    bus.o_ImmSrc = 3'b100;
            default:   bus.o_ImmSrc = 3'b000;
        endcase
    end

    assign bus.o_PCWrite    = i_Rst_n && ((state == FETCH && ready) || (state == BRANCH && taken)
                                          || state == JAL || state == JALR2);
    assign bus.o_IRWrite    = i_Rst_n && state == FETCH && ready;
    assign bus.o_Illegal    = i_Rst_n && state == DECODE && dec_illegal;
    assign bus.o_AdrSrc     = ctrl.adr_src;
    assign bus.o_MemWrite   = ctrl.mem_write;
    assign bus.o_ResultSrc  = ctrl.result_src;
    assign bus.o_ALUSrcA    = ctrl.src_a;
    assign bus.o_ALUSrcB    = ctrl.src_b;
    assign bus.o_RegWrite   = ctrl.reg_write;
    assign bus.o_ALUControl = ctrl.alu_control;
    assign bus.o_State      = state;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: per-cycle expected output vectors are queued
// as stimulus is driven and compared against the DUT on the falling edge.
module tb_multicycle_control_unit;
    logic clk;
    logic rst_n;

    multicycle_control_unit_if b0();
    multicycle_control_unit_if b1();

    multicycle_control_unit dut (.i_Clk(clk), .i_Rst_n(rst_n), .bus(b0));
    multicycle_control_unit #(.EXT_BRANCH(1'b0), .MEM_HANDSHAKE(1'b0)) dut_nb (
        .i_Clk(clk), .i_Rst_n(rst_n), .bus(b1));

    int errors = 0;
    int checks = 0;
    int sel    = 0;
    string tname;
    logic [6:0] cur_op;
    logic [2:0] cur_f3;
    logic       cur_f7;
    logic       cur_rtype;

    logic [22:0] exp_q[$];
    int          st_q[$];
    bit          rdy_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [22:0] obs();
        if (sel == 0)
            return {b0.o_State, b0.o_PCWrite, b0.o_AdrSrc, b0.o_MemWrite, b0.o_IRWrite,
                    b0.o_ResultSrc, b0.o_ALUSrcA, b0.o_ALUSrcB, b0.o_ImmSrc, b0.o_RegWrite,
                    b0.o_ALUControl, b0.o_Illegal};
        return {b1.o_State, b1.o_PCWrite, b1.o_AdrSrc, b1.o_MemWrite, b1.o_IRWrite,
                b1.o_ResultSrc, b1.o_ALUSrcA, b1.o_ALUSrcB, b1.o_ImmSrc, b1.o_RegWrite,
                b1.o_ALUControl, b1.o_Illegal};
    endfunction

    function automatic logic [3:0] alu_ref(input logic [2:0] f3, input logic f7, input logic rt);
        case (f3)
            3'd0: return (rt && f7) ? 4'd1 : 4'd0;
            3'd1: return 4'd7;
            3'd2: return 4'd5;
            3'd3: return 4'd6;
            3'd4: return 4'd4;
            3'd5: return f7 ? 4'd9 : 4'd8;
            3'd6: return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    function automatic logic [22:0] exp_vec(input int st, input bit r, input bit ill, input bit tk);
        logic       pcw, adr, mw, irw, rw, il;
        logic [1:0] res, a, b;
        logic [2:0] imm;
        logic [3:0] alu;
        logic [3:0] s;
        bit         rdy;
        s = st[3:0];
        {pcw, adr, mw, irw, rw, il} = '0;
        {res, a, b} = '0;
        alu = 4'd0;
        rdy = r || (sel == 1);
        case (cur_op)
            7'b0100011: imm = 3'd1;
            7'b1100011: imm = 3'd2;
            7'b1101111: imm = 3'd3;
            7'b0110111: imm = 3'd4;
            default:    imm = 3'd0;
        endcase
        case (st)
            0:  begin b = 2; res = 2; pcw = rdy; irw = rdy; end
            1:  begin a = 1; b = 1; il = ill; end
            2:  begin a = 2; b = 1; end
            3:  adr = 1;
            4:  begin res = 1; rw = 1; end
            5:  begin adr = 1; mw = 1; end
            6:  begin a = 2; alu = alu_ref(cur_f3, cur_f7, 1'b1); end
            7:  begin a = 2; b = 1; alu = alu_ref(cur_f3, cur_f7, 1'b0); end
            8:  rw = 1;
            9:  begin a = 2; alu = 4'd1; pcw = tk; end
            10: begin a = 1; b = 2; pcw = 1; end
            11: begin a = 2; b = 1; end
            12: begin a = 1; b = 2; pcw = 1; end
            default: begin a = 3; b = 1; end
        endcase
        return {s, pcw, adr, mw, irw, res, a, b, imm, rw, alu, il};
    endfunction

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic [3:0] znvc);
        cur_op = op; cur_f3 = f3; cur_f7 = f7; cur_rtype = (op == 7'b0110011);
        b0.i_OpCode = op; b0.i_funct3 = f3; b0.i_funct7_5 = f7;
        b1.i_OpCode = op; b1.i_funct3 = f3; b1.i_funct7_5 = f7;
        {b0.i_Zero, b0.i_Negative, b0.i_Overflow, b0.i_Carry} = znvc;
        {b1.i_Zero, b1.i_Negative, b1.i_Overflow, b1.i_Carry} = znvc;
    endtask

    task automatic add(input int st, input bit r);
        st_q.push_back(st);
        rdy_q.push_back(r);
    endtask

    // Drives one cycle per queued state; the expected vector is queued with the stimulus.
    task automatic run(input bit ill, input bit tk);
        logic [22:0] got, want;
        int st;
        bit r;
        int cyc;
        cyc = 0;
        while (st_q.size() > 0) begin
            st = st_q.pop_front();
            r  = rdy_q.pop_front();
            b0.i_MemReady = r;
            b1.i_MemReady = r;
            exp_q.push_back(exp_vec(st, r, ill, tk));
            @(negedge clk);
            got  = obs();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s cyc%0d: got state=%0d vec=%h, want state=%0d vec=%h",
                         tname, cyc, got[22:19], got, want[22:19], want);
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        tname = "reset";
        set_instr(7'b0110011, 3'd0, 1'b0, 4'd0);
        b0.i_MemReady = 1'b1; b1.i_MemReady = 1'b1;
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (b0.o_State !== 4'd0 || b0.o_PCWrite !== 1'b0 || b0.o_IRWrite !== 1'b0 ||
            b0.o_MemWrite !== 1'b0 || b0.o_RegWrite !== 1'b0 || b0.o_Illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_enables: got state=%0d pcw=%b irw=%b mw=%b rw=%b ill=%b, want 0 all",
                     b0.o_State, b0.o_PCWrite, b0.o_IRWrite, b0.o_MemWrite, b0.o_RegWrite, b0.o_Illegal);
        end
        checks++;
        if ({b0.o_ALUSrcA, b0.o_ALUSrcB, b0.o_ResultSrc, b0.o_AdrSrc, b0.o_ALUControl} !== 11'b00_10_10_0_0000) begin
            errors++;
            $display("FAIL reset_selects: got a=%b b=%b res=%b adr=%b alu=%b, want a=00 b=10 res=10 adr=0 alu=0000",
                     b0.o_ALUSrcA, b0.o_ALUSrcB, b0.o_ResultSrc, b0.o_AdrSrc, b0.o_ALUControl);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_alu();
        tname = "add";
        set_instr(7'b0110011, 3'd0, 1'b0, 4'd0);
        add(0, 1); add(1, 1); add(6, 1); add(8, 1); run(0, 0);
        tname = "sub";
        set_instr(7'b0110011, 3'd0, 1'b1, 4'd0);
        add(0, 1); add(1, 1); run(0, 0);
        @(negedge clk);
        checks++;
        if (b0.o_ALUControl !== 4'b0001) begin
            errors++;
            $display("FAIL sub_alu: got %b want 0001", b0.o_ALUControl);
        end
        @(posedge clk); #1;
        add(8, 1); run(0, 0);
        tname = "addi_f7";
        set_instr(7'b0010011, 3'd0, 1'b1, 4'd0);
        add(0, 1); add(1, 1); add(7, 1); add(8, 1); run(0, 0);
        tname = "alu_rand";
        for (int i = 0; i < 8; i++) begin
            set_instr($urandom_range(0, 1) ? 7'b0110011 : 7'b0010011,
                      3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 4'd0);
            add(0, 1); add(1, 1); add(cur_rtype ? 6 : 7, 1); add(8, 1); run(0, 0);
        end
    endtask

    task automatic test_mem_stall();
        tname = "lw_stall";
        set_instr(7'b0000011, 3'd2, 1'b0, 4'd0);
        add(0, 1); add(1, 1); add(2, 1); add(3, 0); add(3, 0); add(3, 1); add(4, 1); run(0, 0);
        tname = "sw_fetch_stall";
        set_instr(7'b0100011, 3'd2, 1'b0, 4'd0);
        add(0, 0); add(0, 1); add(1, 1); add(2, 1); add(5, 0); add(5, 1); run(0, 0);
    endtask

    task automatic test_branch();
        // znvc = {Zero, Negative, Overflow, Carry}
        tname = "bne_z0";   set_instr(7'b1100011, 3'd1, 1'b0, 4'b0000);
        add(0, 1); add(1, 1); add(9, 1); run(0, 1);
        tname = "bltu_c1";  set_instr(7'b1100011, 3'd6, 1'b0, 4'b0001);
        add(0, 1); add(1, 1); add(9, 1); run(0, 0);
        tname = "bge_n1v1"; set_instr(7'b1100011, 3'd5, 1'b0, 4'b0110);
        add(0, 1); add(1, 1); add(9, 1); run(0, 1);
        tname = "beq_z1";   set_instr(7'b1100011, 3'd0, 1'b0, 4'b1000);
        add(0, 1); add(1, 1); add(9, 1); run(0, 1);
        tname = "blt_n1v0"; set_instr(7'b1100011, 3'd4, 1'b0, 4'b0100);
        add(0, 1); add(1, 1); add(9, 1); run(0, 1);
        tname = "bgeu_c0";  set_instr(7'b1100011, 3'd7, 1'b0, 4'b0000);
        add(0, 1); add(1, 1); add(9, 1); run(0, 0);
        tname = "br_f3_010"; set_instr(7'b1100011, 3'd2, 1'b0, 4'b1000);
        add(0, 1); add(1, 1); run(1, 0);
    endtask

    task automatic test_jump();
        tname = "jal";  set_instr(7'b1101111, 3'd0, 1'b0, 4'd0);
        add(0, 1); add(1, 1); add(10, 1); add(8, 1); run(0, 0);
        tname = "jalr"; set_instr(7'b1100111, 3'd0, 1'b0, 4'd0);
        add(0, 1); add(1, 1); add(11, 1); add(12, 1); add(8, 1); run(0, 0);
        tname = "lui";  set_instr(7'b0110111, 3'd3, 1'b1, 4'd0);
        add(0, 1); add(1, 1); add(13, 1); add(8, 1); run(0, 0);
        tname = "jalr_f3"; set_instr(7'b1100111, 3'd1, 1'b0, 4'd0);
        add(0, 1); add(1, 1); run(1, 0);
        tname = "fence_illegal"; set_instr(7'b0001111, 3'd0, 1'b0, 4'd0);
        add(0, 1); add(1, 1); add(0, 1); run(1, 0);
    endtask

    task automatic test_ext_branch0();
        sel = 1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tname = "nb_bne";  set_instr(7'b1100011, 3'd1, 1'b0, 4'b0000);
        add(0, 0); add(1, 0); run(1, 0);
        tname = "nb_beq";  set_instr(7'b1100011, 3'd0, 1'b0, 4'b1000);
        add(0, 0); add(1, 0); add(9, 0); run(0, 1);
        tname = "nb_lw";   set_instr(7'b0000011, 3'd2, 1'b0, 4'd0);
        add(0, 0); add(1, 0); add(2, 0); add(3, 0); add(4, 0); add(0, 0); run(0, 0);
        sel = 0;
    endtask

    task automatic test_reset_mid_sw();
        tname = "sw_pre_reset";
        set_instr(7'b0100011, 3'd2, 1'b0, 4'd0);
        add(0, 1); add(1, 1); add(2, 1); add(5, 0); add(5, 0); run(0, 0);
        checks++;
        if (b0.o_MemWrite !== 1'b1) begin
            errors++;
            $display("FAIL sw_stall_mw: got %b want 1", b0.o_MemWrite);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (b0.o_MemWrite !== 1'b0 || b0.o_State !== 4'd0 || b0.o_PCWrite !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got mw=%b state=%0d pcw=%b, want mw=0 state=0 pcw=0",
                     b0.o_MemWrite, b0.o_State, b0.o_PCWrite);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tname = "post_reset";
        add(0, 0); add(0, 0); add(0, 1); add(1, 1); add(2, 1); add(5, 1); add(0, 1); run(0, 0);
    endtask

    initial begin
        rst_n = 1'b1;
        set_instr(7'b0110011, 3'd0, 1'b0, 4'd0);
        b0.i_MemReady = 1'b0; b1.i_MemReady = 1'b0;
        test_reset();
        test_alu();
        test_mem_stall();
        test_branch();
        test_jump();
        test_ext_branch0();
        test_reset_mid_sw();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end
endmodule
